// File: rtl/work_loader.sv
// Work-unit deserializer: collects 8 midstate words and 3 header-tail words from the
// 32-bit shift-out stream and presents the midstate plus padded second SHA-256 block.
module work_loader #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned MID_WORDS  = 8,
    parameter int unsigned TAIL_WORDS = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic                            shift_in_enable,
    input  logic [WORD_WIDTH-1:0]           in_data,
    input  logic                            work_ack,
    output logic                            work_valid,
    output logic [WORD_WIDTH*MID_WORDS-1:0] mid_state,
    output logic [511:0]                    head_data,
    output logic [3:0]                      word_count,
    output logic                            load_error
);

    localparam int unsigned MID_TOP  = WORD_WIDTH * MID_WORDS - 1;
    localparam logic [3:0]  LAST_MID = 4'(MID_WORDS - 1);
    localparam logic [3:0]  LAST_ALL = 4'(MID_WORDS + TAIL_WORDS - 1);

    // Nonce seed, SHA-256 pad bit, zero fill and the 640-bit message length.
    localparam logic [415:0] HEAD_FIXED = {32'h0, 32'h80000000, 320'h0, 32'h00000280};

    typedef enum logic [1:0] {
        IDLE,
        LOAD_MID,
        LOAD_TAIL,
        PRESENT
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            work_valid <= 1'b0;
            mid_state  <= '0;
            head_data  <= '0;
            word_count <= '0;
            load_error <= 1'b0;
        end else if (frame_start) begin
            // Restart wins over everything, including a same-cycle ack.
            state             <= LOAD_MID;
            work_valid        <= 1'b0;
            head_data[415:0]  <= HEAD_FIXED;
            if (state == IDLE || state == PRESENT)
                load_error <= 1'b0;
            if (shift_in_enable) begin
                mid_state[MID_TOP -: WORD_WIDTH] <= in_data;
                word_count                       <= 4'd1;
            end else begin
                word_count <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (shift_in_enable)
                        load_error <= 1'b1;
                end
                LOAD_MID: begin
                    if (shift_in_enable) begin
                        for (int unsigned i = 0; i < MID_WORDS; i++)
                            if (word_count == 4'(i))
                                mid_state[MID_TOP - WORD_WIDTH*i -: WORD_WIDTH] <= in_data;
                        word_count <= word_count + 4'd1;
                        if (word_count == LAST_MID)
                            state <= LOAD_TAIL;
                    end
                end
                LOAD_TAIL: begin
                    if (shift_in_enable) begin
                        for (int unsigned i = 0; i < TAIL_WORDS; i++)
                            if (word_count == 4'(MID_WORDS + i))
                                head_data[511 - WORD_WIDTH*i -: WORD_WIDTH] <= in_data;
                        word_count <= word_count + 4'd1;
                        if (word_count == LAST_ALL) begin
                            state      <= PRESENT;
                            work_valid <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (shift_in_enable)
                        load_error <= 1'b1;
                    if (work_ack) begin
                        state      <= IDLE;
                        work_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_work_loader.sv
// Self-checking bench for work_loader: directed scenarios followed by random traffic,
// compared every cycle against a word-array reference model.
module tb_work_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_start;
    logic         shift_in_enable;
    logic [31:0]  in_data;
    logic         work_ack;
    logic         work_valid;
    logic [255:0] mid_state;
    logic [511:0] head_data;
    logic [3:0]   word_count;
    logic         load_error;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: the unit as an array of words plus a few flags.
    logic [31:0] m_words [11];
    int          m_cnt;
    bit          m_loading;
    bit          m_valid;
    bit          m_err;
    bit          m_framed;

    always #5 clk = ~clk;

    work_loader #(.WORD_WIDTH(32), .MID_WORDS(8), .TAIL_WORDS(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .shift_in_enable (shift_in_enable),
        .in_data         (in_data),
        .work_ack        (work_ack),
        .work_valid      (work_valid),
        .mid_state       (mid_state),
        .head_data       (head_data),
        .word_count      (word_count),
        .load_error      (load_error)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit fs, input bit se,
                                input logic [31:0] d, input bit ack);
        if (rst) begin
            foreach (m_words[i]) m_words[i] = '0;
            m_cnt = 0; m_loading = 0; m_valid = 0; m_err = 0; m_framed = 0;
        end else if (fs) begin
            if (!m_loading) m_err = 0;
            m_loading = 1; m_valid = 0; m_framed = 1; m_cnt = 0;
            if (se) begin
                m_words[0] = d;
                m_cnt = 1;
            end
        end else if (m_loading) begin
            if (se) begin
                m_words[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 11) begin
                    m_loading = 0;
                    m_valid = 1;
                end
            end
        end else if (m_valid) begin
            if (se) m_err = 1;
            if (ack) m_valid = 0;
        end else if (se) begin
            m_err = 1;
        end
    endtask

    task automatic compare_all();
        logic [255:0] exp_mid;
        logic [511:0] exp_head;
        for (int i = 0; i < 8; i++) exp_mid[255 - 32*i -: 32] = m_words[i];
        exp_head = '0;
        for (int i = 0; i < 3; i++) exp_head[511 - 32*i -: 32] = m_words[8 + i];
        if (m_framed) exp_head[415:0] = {32'h0, 32'h80000000, 320'h0, 32'h00000280};
        check("work_valid", 512'(work_valid), 512'(m_valid));
        check("word_count", 512'(word_count), 512'(m_cnt));
        check("load_error", 512'(load_error), 512'(m_err));
        check("mid_state",  512'(mid_state),  512'(exp_mid));
        check("head_data",  head_data, exp_head);
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare just after the edge.
    task automatic step(input bit rst, input bit fs, input bit se,
                        input logic [31:0] d, input bit ack);
        reset = rst; frame_start = fs; shift_in_enable = se; in_data = d; work_ack = ack;
        @(posedge clk);
        model_update(rst, fs, se, d, ack);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
    endtask

    task automatic load_unit(input logic [31:0] base);
        step(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, base + 32'(i), 0);
    endtask

    initial begin
        reset = 1; frame_start = 0; shift_in_enable = 0; in_data = '0; work_ack = 0;
        foreach (m_words[i]) m_words[i] = '0;
        m_cnt = 0; m_loading = 0; m_valid = 0; m_err = 0; m_framed = 0;

        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);

        // Orphan word then stray ack in IDLE.
        step(0, 0, 1, 32'hCAFEF00D, 0);
        check("orphan_err", 512'(load_error), 512'(1));
        step(0, 0, 0, 32'h0, 1);
        check("stray_ack_cnt", 512'(word_count), 512'(0));

        // Nominal load with words 0..A.
        load_unit(32'h0);
        check("nom_pad",   512'(head_data[383:352]), 512'(32'h80000000));
        check("nom_len",   512'(head_data[31:0]),    512'(32'h00000280));
        check("nom_word7", 512'(mid_state[31:0]),    512'(32'h7));

        // Hold ack low for 5 cycles, then pulse it.
        idle(5);
        step(0, 0, 0, 32'h0, 1);
        check("ack_drop", 512'(work_valid), 512'(0));
        idle(2);

        // Restart mid-load with a simultaneous word.
        step(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h100 + 32'(i), 0);
        step(0, 1, 1, 32'hDEADBEEF, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h200 + 32'(i), 0);
        check("restart_w0", 512'(mid_state[255:224]), 512'(32'hDEADBEEF));

        // Overrun in PRESENT; error survives ack and clears on next frame.
        step(0, 0, 1, 32'h12345678, 0);
        step(0, 0, 0, 32'h0, 1);
        idle(1);
        step(0, 1, 0, 32'h0, 0);
        check("err_cleared", 512'(load_error), 512'(0));

        // Reset mid-load, then orphan words.
        for (int i = 0; i < 7; i++) step(0, 0, 1, 32'h300 + 32'(i), 0);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h400, 0);
        step(0, 0, 1, 32'h401, 0);

        // frame_start wins over same-cycle ack in PRESENT.
        load_unit(32'h500);
        step(0, 1, 0, 32'h0, 1);
        check("fs_over_ack", 512'(work_valid), 512'(0));

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bit fs, se, ack, rst;
            rst = ($urandom_range(0, 199) == 0);
            fs  = ($urandom_range(0, 29) == 0);
            se  = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 5) == 0);
            step(rst, fs, se, $urandom, ack);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
